// File: rtl/servant_arb_pkg.sv
// ============================================================================
// servant_arb_pkg : shared types and helpers for the servant RAM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package servant_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Width of a master index; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/servant_rr_pick.sv
// ============================================================================
// servant_rr_pick : combinational rotate-priority encoder, search starts at last+1
// Rev 1.0
// ============================================================================
`default_nettype none

module servant_rr_pick
    import servant_arb_pkg::*;
#(
    parameter int CORE_COUNT = 3
) (
    input  logic [CORE_COUNT-1:0]         req,
    input  logic [idx_w(CORE_COUNT)-1:0]  last,
    output logic [idx_w(CORE_COUNT)-1:0]  gnt_idx,
    output logic                          gnt_valid
);

    localparam int IW = idx_w(CORE_COUNT);

    always_comb begin
        int cand;
        cand      = 0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // The previous winner is visited last, giving it the lowest priority.
        for (int i = 1; i <= CORE_COUNT; i++) begin
            cand = int'(last) + i;
            if (cand >= CORE_COUNT) begin
                cand = cand - CORE_COUNT;
            end
            if (!gnt_valid && req[IW'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/servant_wb_arbiter.sv
// ============================================================================
// servant_wb_arbiter : round-robin cyc-only Wishbone arbiter for the servant RAM
// Optional watchdog release enabled by defining SERVANT_ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module servant_wb_arbiter
    import servant_arb_pkg::*;
#(
    parameter int CORE_COUNT     = 3,
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic [CORE_COUNT*AW-1:0] i_m_adr,
    input  logic [CORE_COUNT*32-1:0] i_m_dat,
    input  logic [CORE_COUNT*4-1:0]  i_m_sel,
    input  logic [CORE_COUNT-1:0]    i_m_we,
    input  logic [CORE_COUNT-1:0]    i_m_cyc,
    output logic [31:0]              o_m_rdt,
    output logic [CORE_COUNT-1:0]    o_m_ack,
    output logic [AW-1:0]            o_s_adr,
    output logic [31:0]              o_s_dat,
    output logic [3:0]               o_s_sel,
    output logic                     o_s_we,
    output logic                     o_s_cyc,
    input  logic [31:0]              i_s_rdt,
    input  logic                     i_s_ack,
    output logic                     o_timeout
);

    localparam int IW = idx_w(CORE_COUNT);

    if (CORE_COUNT < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("servant_wb_arbiter: CORE_COUNT must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] w_grant_nxt;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_last_nxt;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic          w_gnt_cyc;
    logic          w_ack_fire;
    logic          w_expire;
    logic [AW-1:0] w_adr_mux;
    logic [31:0]   w_dat_mux;
    logic [3:0]    w_sel_mux;
    logic          w_we_mux;

    servant_rr_pick #(
        .CORE_COUNT (CORE_COUNT)
    ) u_pick (
        .req       (i_m_cyc),
        .last      (r_last),
        .gnt_idx   (w_pick_idx),
        .gnt_valid (w_pick_valid)
    );

    always_comb begin
        w_gnt_cyc = 1'b0;
        w_adr_mux = '0;
        w_dat_mux = '0;
        w_sel_mux = '0;
        w_we_mux  = 1'b0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            if (r_grant == IW'(k)) begin
                w_gnt_cyc = i_m_cyc[k];
                w_adr_mux = i_m_adr[k*AW +: AW];
                w_dat_mux = i_m_dat[k*32 +: 32];
                w_sel_mux = i_m_sel[k*4 +: 4];
                w_we_mux  = i_m_we[k];
            end
        end
    end

`ifdef SERVANT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_busy_cnt;
    logic          r_timeout;

    // Counter is zero on the first BUSY cycle, so expiry lands on BUSY cycle TIMEOUT_CYCLES.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_busy_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == ARB_IDLE) begin
                r_busy_cnt <= '0;
            end else begin
                r_busy_cnt <= r_busy_cnt + CW'(1);
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_expire  = (r_state == ARB_BUSY) && w_gnt_cyc && !i_s_ack &&
                       (r_busy_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign o_timeout = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= IW'(CORE_COUNT - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_ack_fire  = 1'b0;
        o_s_cyc     = 1'b0;
        o_s_adr     = '0;
        o_s_dat     = '0;
        o_s_sel     = '0;
        o_s_we      = 1'b0;
        o_m_rdt     = i_s_rdt;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                end
            end
            ARB_BUSY: begin
                o_s_cyc    = w_gnt_cyc;
                o_s_adr    = w_adr_mux;
                o_s_dat    = w_dat_mux;
                o_s_sel    = w_sel_mux;
                o_s_we     = w_we_mux;
                // An ack against a dropped request belongs to nobody and is discarded.
                w_ack_fire = w_gnt_cyc && i_s_ack;
                if (w_expire) begin
                    o_m_rdt = '0;
                end
                if (!w_gnt_cyc || w_ack_fire || w_expire) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    for (genvar k = 0; k < CORE_COUNT; k++) begin : g_ack
        assign o_m_ack[k] = (w_ack_fire || w_expire) && (r_grant == IW'(k));
    end

endmodule

`default_nettype wire

// File: tb/tb_servant_wb_arbiter.sv
// ============================================================================
// tb_servant_wb_arbiter : directed scenarios plus randomized traffic vs. a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_servant_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] m_adr;
    logic [N*32-1:0] m_dat;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_cyc;
    logic [31:0]     m_rdt;
    logic [N-1:0]    m_ack;
    logic [AW-1:0]   s_adr;
    logic [31:0]     s_dat;
    logic [3:0]      s_sel;
    logic            s_we;
    logic            s_cyc;
    logic [31:0]     s_rdt;
    logic            s_ack;
    logic            timeout;

    always #5 clk = ~clk;

    servant_wb_arbiter #(
        .CORE_COUNT     (N),
        .AW             (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk    (clk),
        .wb_rst    (rst),
        .i_m_adr   (m_adr),
        .i_m_dat   (m_dat),
        .i_m_sel   (m_sel),
        .i_m_we    (m_we),
        .i_m_cyc   (m_cyc),
        .o_m_rdt   (m_rdt),
        .o_m_ack   (m_ack),
        .o_s_adr   (s_adr),
        .o_s_dat   (s_dat),
        .o_s_sel   (s_sel),
        .o_s_we    (s_we),
        .o_s_cyc   (s_cyc),
        .i_s_rdt   (s_rdt),
        .i_s_ack   (s_ack),
        .o_timeout (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the slave, who won last, how long the access has run.
    bit           md_busy;
    int           md_owner;
    int           md_last;
    int           md_cnt;
    bit           md_to;
    logic [N-1:0] last_ack;
    logic [N-1:0] obs_ack;
    logic         obs_s_cyc;
    logic [AW-1:0] obs_s_adr;
    logic [31:0]  obs_rdt;

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        int k;
        for (int i = 1; i <= N; i++) begin
            k = (last + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        md_busy  = 0;
        md_owner = 0;
        md_last  = N - 1;
        md_cnt   = 0;
        md_to    = 0;
        last_ack = '0;
    endtask

    task automatic step();
        bit           g;
        bit           ack_e;
        bit           expire;
        logic [N-1:0] exp_ack;
        int           p;
        @(negedge clk);
        g      = md_busy && m_cyc[md_owner];
        ack_e  = g && s_ack;
        expire = 0;
`ifdef SERVANT_ARB_TIMEOUT_EN
        expire = g && !s_ack && (md_cnt == TO - 1);
`endif
        exp_ack = '0;
        if (ack_e || expire) exp_ack[md_owner] = 1'b1;
        check_eq("s_cyc", s_cyc, g);
        check_eq("s_adr", s_adr, md_busy ? m_adr[md_owner*AW +: AW] : '0);
        check_eq("s_dat", s_dat, md_busy ? m_dat[md_owner*32 +: 32] : '0);
        check_eq("s_sel", s_sel, md_busy ? m_sel[md_owner*4 +: 4] : '0);
        check_eq("s_we", s_we, md_busy ? m_we[md_owner] : 1'b0);
        check_eq("m_ack", m_ack, exp_ack);
        if (exp_ack != '0) check_eq("m_rdt", m_rdt, expire ? 32'h0 : s_rdt);
        check_eq("timeout", timeout, md_to);
        obs_ack   = m_ack;
        obs_s_cyc = s_cyc;
        obs_s_adr = s_adr;
        obs_rdt   = m_rdt;
        last_ack  = exp_ack;
        if (expire) md_to = 1;
        if (md_busy) begin
            if (!g || ack_e || expire) md_busy = 0;
            else md_cnt++;
        end else begin
            p = rr_pick(m_cyc, md_last);
            if (p >= 0) begin
                md_busy  = 1;
                md_owner = p;
                md_last  = p;
                md_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Step until an ack is seen or the budget runs out; returns cycles used.
    task automatic wait_ack(input string tag, input int budget, output int used);
        used = 0;
        do begin
            step();
            used++;
        end while (obs_ack == '0 && used < budget);
        if (obs_ack == '0) check_eq({tag, "_no_ack"}, 0, 1);
    endtask

    function automatic logic [31:0] fixed_adr(input int k);
        return 32'h1000_0000 + 32'(k * 16);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] acks[$];
        logic [N-1:0] exp_order[4];
        int used;

        rst   = 1'b1;
        m_cyc = '0;
        m_we  = '0;
        m_dat = '0;
        m_sel = '0;
        s_ack = 1'b0;
        s_rdt = '0;
        for (int k = 0; k < N; k++) begin
            m_adr[k*AW +: AW] = fixed_adr(k);
            m_dat[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            m_sel[k*4 +: 4]   = 4'(k + 1);
        end
        model_reset();

        // Reset state
        @(negedge clk);
        check_eq("rst_s_cyc", s_cyc, 1'b0);
        check_eq("rst_m_ack", m_ack, '0);
        check_eq("rst_timeout", timeout, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All masters requesting, one-cycle slave: order 0,1,2,0
        m_cyc = 3'b111;
        s_ack = 1'b1;
        s_rdt = 32'hCAFE_0001;
        for (int i = 0; i < 20 && acks.size() < 4; i++) begin
            step();
            if (obs_ack != '0) acks.push_back(obs_ack);
        end
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
        check_eq("order_count", acks.size(), 4);
        for (int i = 0; i < acks.size() && i < 4; i++) check_eq("order", acks[i], exp_order[i]);

        // Contention skip: last=0, masters 2 and 0 requesting
        acks.delete();
        m_cyc = 3'b101;
        for (int i = 0; i < 12 && acks.size() < 2; i++) begin
            step();
            if (obs_ack != '0) acks.push_back(obs_ack);
        end
        check_eq("skip_count", acks.size(), 2);
        if (acks.size() == 2) begin
            check_eq("skip_first", acks[0], 3'b100);
            check_eq("skip_second", acks[1], 3'b001);
        end

        // Abort: master 0 owns, master 1 pending, master 0 drops
        s_ack = 1'b0;
        m_cyc = 3'b001;
        step();
        m_cyc = 3'b011;
        step();
        check_eq("abort_owner_adr", obs_s_adr, fixed_adr(0));
        m_cyc = 3'b010;
        step();
        check_eq("abort_cyc", obs_s_cyc, 1'b0);
        check_eq("abort_ack", obs_ack, '0);
        step();
        step();
        check_eq("abort_next_cyc", obs_s_cyc, 1'b1);
        check_eq("abort_next_adr", obs_s_adr, fixed_adr(1));

        // Asynchronous reset between clock edges while BUSY
        m_cyc = 3'b111;
        s_ack = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_s_cyc", s_cyc, 1'b0);
        check_eq("async_m_ack", m_ack, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_ack("post_rst", 10, used);
        check_eq("post_rst_first", obs_ack, 3'b001);

`ifdef SERVANT_ARB_TIMEOUT_EN
        // Silent slave: watchdog acks on BUSY cycle TO with zero data
        m_cyc = '0;
        s_ack = 1'b0;
        step();
        step();
        m_cyc = 3'b010;
        wait_ack("to", 20, used);
        check_eq("to_latency", used, TO + 1);
        check_eq("to_ack", obs_ack, 3'b010);
        check_eq("to_rdt", obs_rdt, 32'h0);
        m_cyc = 3'b100;
        s_ack = 1'b1;
        wait_ack("to_next", 10, used);
        check_eq("to_next_ack", obs_ack, 3'b100);
        check_eq("to_sticky", timeout, 1'b1);
`endif

        // Randomized traffic with aborts and spurious slave acks
        m_cyc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (m_cyc[k]) begin
                    if (last_ack[k] || ($urandom % 20) == 0) m_cyc[k] = 1'b0;
                end else if (($urandom % 3) == 0) begin
                    m_cyc[k]          = 1'b1;
                    m_adr[k*AW +: AW] = $urandom;
                    m_dat[k*32 +: 32] = $urandom;
                    m_sel[k*4 +: 4]   = 4'($urandom);
                    m_we[k]           = 1'($urandom);
                end
            end
            s_ack = (($urandom % 3) == 0);
            s_rdt = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
